// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity encodings, frame FSM states,
// error_flag bit positions and the parity reference function.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE0 = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE3 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5,
        ST_BREAK  = 3'd6
    } state_t;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_OVERRUN = 2;

    function automatic logic has_parity(input parity_t p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

    // Data narrower than 8 bits is zero-extended, which leaves the XOR unchanged.
    function automatic logic expected_parity(input logic [7:0] d, input parity_t p);
        case (p)
            PAR_ODD:  return ~^d;
            PAR_EVEN: return ^d;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Host-side byte handshake of the UART receiver: data, flags, valid/ready.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [2:0]           error_flag;

    modport master (output rx_data, output rx_valid, output error_flag, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input error_flag, output rx_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the raw line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: oversampled start/data/parity/stop walk,
// error detection and a single-entry valid/ready output register with overrun.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    input  logic [1:0]            parity_type,
    uart_rx_frame_ctrl_if.master  host,
    output logic                  busy
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rx_sync_s;
    state_t               state_r, state_next_s;
    logic [TICK_W-1:0]    tick_cnt_r;
    logic [TICK_W-1:0]    tick_last_s;
    logic                 sample_s;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    parity_t              par_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic [2:0]           error_r;
    logic                 busy_r;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_in),
        .q       (rx_sync_s)
    );

    // Sample strobe: mid start bit after half a period, then once per full period
    always_comb begin
        tick_last_s = FULL_LAST;
        sample_s    = 1'b0;
        if (state_r == ST_START) begin
            tick_last_s = HALF_LAST;
        end else begin
            tick_last_s = FULL_LAST;
        end
        case (state_r)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: sample_s = baud_tick && (tick_cnt_r == tick_last_s);
            default:                               sample_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = rx_sync_s ? ST_IDLE : ST_START;
            ST_START: begin
                if (sample_s) begin
                    state_next_s = rx_sync_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s && (bit_cnt_r == LAST_BIT)) begin
                    state_next_s = has_parity(par_r) ? ST_PARITY : ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: state_next_s = sample_s ? ST_STOP : ST_PARITY;
            ST_STOP:   state_next_s = sample_s ? ST_DONE : ST_STOP;
            ST_DONE:   state_next_s = rx_sync_s ? ST_IDLE : ST_BREAK;
            ST_BREAK:  state_next_s = rx_sync_s ? ST_IDLE : ST_BREAK;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Tick/bit counters, shift register and per-frame error capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_r      <= PAR_NONE0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && !rx_sync_s) begin
                tick_cnt_r <= '0;
            end else if (sample_s) begin
                tick_cnt_r <= '0;
            end else if (baud_tick) begin
                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
            if (sample_s) begin
                case (state_r)
                    ST_START: begin
                        bit_cnt_r <= '0;
                        par_r     <= parity_t'(parity_type);
                        perr_r    <= 1'b0;
                    end
                    ST_DATA: begin
                        shift_r   <= {rx_sync_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                    ST_PARITY: perr_r <= (rx_sync_s != expected_parity(8'(shift_r), par_r));
                    ST_STOP:   ferr_r <= ~rx_sync_s;
                    default:   ;
                endcase
            end
        end
    end

    // Host output register: load on DONE, flag overrun if still full, clear on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            error_r    <= 3'b000;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (state_r == ST_DONE) begin
                if (!rx_valid_r || host.rx_ready) begin
                    rx_data_r  <= shift_r;
                    rx_valid_r <= 1'b1;
                    error_r    <= {1'b0, ferr_r, perr_r};
                end else begin
                    error_r[ERR_OVERRUN] <= 1'b1;
                end
            end else if (rx_valid_r && host.rx_ready) begin
                rx_valid_r <= 1'b0;
                error_r    <= 3'b000;
            end
        end
    end

    assign host.rx_data    = rx_data_r;
    assign host.rx_valid   = rx_valid_r;
    assign host.error_flag = error_r;
    assign busy            = busy_r;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized scoreboard bench for uart_rx_frame_ctrl: frames are built from
// byte/parity/stop choices and the expected host word is queued per frame.
module tb_uart_rx_frame_ctrl;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] flags;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       busy;

    uart_rx_frame_ctrl_if #(.DATA_BITS(DATA_BITS)) hif ();

    uart_rx_frame_ctrl #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .parity_type (parity_type),
        .host        (hif),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Host model + monitor: pick ready, then compare any transfer the next edge will take
    initial begin
        exp_t e;
        hif.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            hif.rx_ready = (ready_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (reset_n && hif.rx_valid && hif.rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got data 0x%0h flags %b, expected no frame",
                             hif.rx_data, hif.error_flag);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", 32'(hif.rx_data), 32'(e.data));
                    chk("error_flag", 32'(hif.error_flag), 32'(e.flags));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic line_for(input logic v, input int periods);
        rx_in = v;
        repeat (periods * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input bit flip_par,
                              input bit stop_bit, input int extra_low, input bit push);
        bit   has_p;
        logic pbit;
        exp_t e;
        has_p = (pt == 2'b01) || (pt == 2'b10);
        pbit  = (pt == 2'b01) ? ~^d : ^d;
        parity_type = pt;
        if (push) begin
            e.data  = d;
            e.flags = {1'b0, ~stop_bit, has_p & flip_par};
            exp_q.push_back(e);
        end
        line_for(1'b0, 1);
        for (int i = 0; i < DATA_BITS; i++) line_for(d[i], 1);
        if (has_p) line_for(pbit ^ flip_par, 1);
        line_for(stop_bit, 1);
        if (!stop_bit && extra_low > 0) line_for(1'b0, extra_low);
        line_for(1'b1, 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   n;
        bit   busy_seen;
        bit   valid_seen;
        exp_t e;

        repeat (5) @(negedge clk);
        chk("reset_rx_valid", 32'(hif.rx_valid), 32'd0);
        chk("reset_rx_data", 32'(hif.rx_data), 32'd0);
        chk("reset_error_flag", 32'(hif.error_flag), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        ready_mode = 1;

        send_frame(8'hA5, 2'b10, 1'b0, 1'b1, 0, 1'b1);
        send_frame(8'h01, 2'b01, 1'b1, 1'b1, 0, 1'b1);

        // Stop bit low with the line held low afterwards: receiver must sit in BREAK
        fork
            send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 3, 1'b1);
            begin
                repeat (BIT_CLKS * 23 / 2) @(negedge clk);
                chk("break_busy", 32'(busy), 32'd1);
            end
        join
        repeat (4) @(negedge clk);
        chk("after_break_busy", 32'(busy), 32'd0);
        wait_drain("drain_t3");

        // Short low glitch on an idle line
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
        rx_in = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * BIT_CLKS) begin
            @(negedge clk);
            busy_seen  = busy_seen | busy;
            valid_seen = valid_seen | hif.rx_valid;
        end
        chk("glitch_busy_pulse", 32'(busy_seen), 32'd1);
        chk("glitch_no_valid", 32'(valid_seen), 32'd0);
        chk("glitch_busy_end", 32'(busy), 32'd0);

        // Overrun: two frames with the host stalled
        ready_mode = 0;
        @(negedge clk);
        send_frame(8'h11, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        chk("ovr_valid", 32'(hif.rx_valid), 32'd1);
        chk("ovr_data", 32'(hif.rx_data), 32'h11);
        chk("ovr_flags", 32'(hif.error_flag), 32'b100);
        e.data  = 8'h11;
        e.flags = 3'b100;
        exp_q.push_back(e);
        ready_mode = 1;
        n = 0;
        while (hif.rx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ovr_accept_valid", 32'(hif.rx_valid), 32'd0);
        chk("ovr_accept_flags", 32'(hif.error_flag), 32'd0);
        wait_drain("drain_t5");

        // Reset in the middle of the data bits
        parity_type = 2'b00;
        line_for(1'b0, 1);
        line_for(1'b1, 1);
        line_for(1'b0, 1);
        rx_in = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_data", 32'(hif.rx_data), 32'd0);
        chk("midreset_valid", 32'(hif.rx_valid), 32'd0);
        chk("midreset_flags", 32'(hif.error_flag), 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        line_for(1'b1, 1);
        send_frame(8'h5A, 2'b10, 1'b0, 1'b1, 0, 1'b1);
        wait_drain("drain_t6");

        // Randomized frames
        for (int k = 0; k < 25; k++) begin
            send_frame(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) != 0), $urandom_range(0, 2), 1'b1);
        end
        wait_drain("drain_random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
